// File: rtl/gerador_vai_vem_pkg.sv
// Shared types for the vai/vem generator: FSM state type and target clamp helper.
package gerador_vai_vem_pkg;
`include "gerador_vai_vem_estados.vh"

   typedef enum logic [1:0] {
      ST_OCIOSO = EST_OCIOSO,
      ST_ESPERA = EST_ESPERA,
      ST_PASSO  = EST_PASSO,
      ST_FIM    = EST_FIM
   } estado_t;

   function automatic int unsigned satura(input int unsigned v, input int unsigned topo);
      return (v > topo) ? topo : v;
   endfunction
endpackage

// File: rtl/gerador_vai_vem_contador_passo.sv
// Step timer: counts modulo PASSO while conta=1, synchronous clear, fim at PASSO-1.
// Latency: fim is registered-count decode, zero extra cycles; backpressure: none.
module contador_passo #(
   parameter int PASSO = 50
) (
   input  logic clock,
   input  logic zera_s,
   input  logic limpa,
   input  logic conta,
   output logic fim
);
   localparam int W = (PASSO > 1) ? $clog2(PASSO) : 1;
   localparam logic [W-1:0] TOPO = W'(PASSO - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (limpa) begin
         cnt_d = '0;
      end else if (conta) begin
         cnt_d = (cnt_q == TOPO) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (zera_s) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign fim = (cnt_q == TOPO);
endmodule

// File: rtl/gerador_vai_vem_estados.vh
// State encodings of the vai/vem generator FSM, shared by RTL and bench.
`ifndef GERADOR_VAI_VEM_ESTADOS_VH
`define GERADOR_VAI_VEM_ESTADOS_VH
localparam logic [1:0] EST_OCIOSO = 2'd0;
localparam logic [1:0] EST_ESPERA = 2'd1;
localparam logic [1:0] EST_PASSO  = 2'd2;
localparam logic [1:0] EST_FIM    = 2'd3;
`endif

// File: rtl/gerador_vai_vem.sv
// Paces vai/vem pulses toward a clamped target, mirroring the downstream position.
// Latency: first pulse PASSO cycles after accept, then every PASSO+1; backpressure: none, iniciar ignored while ocupado.
module gerador_vai_vem
   import gerador_vai_vem_pkg::*;
#(
   parameter int M     = 100,
   parameter int N     = 7,
   parameter int PASSO = 50
) (
   input  logic         clock,
   input  logic         zera_s,
   input  logic         iniciar,
   input  logic [N-1:0] alvo,
   output logic         vai,
   output logic         vem,
   output logic [N-1:0] posicao,
   output logic         ocupado,
   output logic         pronto
);
   localparam logic [N-1:0] TOPO = N'(M - 1);

   estado_t      estado_q, estado_d;
   logic [N-1:0] alvo_q, alvo_d;
   logic [N-1:0] posicao_q, posicao_d;
   logic         t_limpa, t_conta, t_fim;
   logic         igual, maior;

   contador_passo #(.PASSO(PASSO)) u_contador_passo (
      .clock  (clock),
      .zera_s (zera_s),
      .limpa  (t_limpa),
      .conta  (t_conta),
      .fim    (t_fim)
   );

   assign igual = (posicao_q == alvo_q);
   assign maior = (alvo_q > posicao_q);

   always_comb begin
      estado_d  = estado_q;
      alvo_d    = alvo_q;
      posicao_d = posicao_q;
      t_limpa   = 1'b0;
      t_conta   = 1'b0;
      vai       = 1'b0;
      vem       = 1'b0;
      pronto    = 1'b0;
      ocupado   = 1'b1;
      case (estado_q)
         ST_OCIOSO: begin
            ocupado = 1'b0;
            t_limpa = 1'b1;
            if (iniciar) begin
               estado_d = ST_ESPERA;
               alvo_d   = N'(satura(32'(alvo), M - 1));
            end
         end
         ST_ESPERA: begin
            if (igual) begin
               estado_d = ST_FIM;
            end else if (t_fim) begin
               estado_d = ST_PASSO;
            end else begin
               t_conta = 1'b1;
            end
         end
         ST_PASSO: begin
            t_limpa  = 1'b1;
            estado_d = ST_ESPERA;
            // Bound guards keep the mirror saturating even if alvo_q were out of range
            if (maior && (posicao_q != TOPO)) begin
               vai       = 1'b1;
               posicao_d = posicao_q + 1'b1;
            end else if (!maior && (posicao_q != '0)) begin
               vem       = 1'b1;
               posicao_d = posicao_q - 1'b1;
            end
         end
         ST_FIM: begin
            pronto   = 1'b1;
            estado_d = ST_OCIOSO;
         end
         default: estado_d = ST_OCIOSO;
      endcase
   end

   always_ff @(posedge clock) begin
      if (zera_s) begin
         estado_q  <= ST_OCIOSO;
         alvo_q    <= '0;
         posicao_q <= '0;
      end else begin
         estado_q  <= estado_d;
         alvo_q    <= alvo_d;
         posicao_q <= posicao_d;
      end
   end

   assign posicao = posicao_q;
endmodule

// File: tb/tb_gerador_vai_vem.sv
// Bench for gerador_vai_vem: timing model of pulses/pronto per move plus a paired vai/vem counter.
module tb_gerador_vai_vem;
   import gerador_vai_vem_pkg::*;

   localparam int M     = 100;
   localparam int N     = 7;
   localparam int PASSO = 4;

   logic         clock = 1'b0;
   logic         zera_s = 1'b1;
   logic         iniciar = 1'b0;
   logic [N-1:0] alvo = '0;
   logic         vai, vem, ocupado, pronto;
   logic [N-1:0] posicao;

   logic [N-1:0] cnt_q;
   logic         cnt_fim;

   int tests = 0;
   int fails = 0;
   int pos_model = 0;

   always #5 clock = ~clock;

   gerador_vai_vem #(.M(M), .N(N), .PASSO(PASSO)) dut (
      .clock   (clock),
      .zera_s  (zera_s),
      .iniciar (iniciar),
      .alvo    (alvo),
      .vai     (vai),
      .vem     (vem),
      .posicao (posicao),
      .ocupado (ocupado),
      .pronto  (pronto)
   );

   // Downstream position counter sharing the same reset
   always_ff @(posedge clock) begin
      if (zera_s) begin
         cnt_q <= '0;
      end else if (vai && (cnt_q != N'(M - 1))) begin
         cnt_q <= cnt_q + 1'b1;
      end else if (vem && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end
   assign cnt_fim = (cnt_q == N'(M - 1));

   task automatic do_reset();
      @(negedge clock);
      zera_s  = 1'b1;
      iniciar = 1'b0;
      repeat (2) @(negedge clock);
      zera_s    = 1'b0;
      pos_model = 0;
   endtask

   // One move: pulses expected at PASSO + k*(PASSO+1), pronto at d*(PASSO+1)+1 cycles after accept
   task automatic run_move(input int a, input int mid_c, input string nome);
      int t, diff, d, fimc, k;
      logic up, e_vai, e_vem, e_pronto, e_ocup;
      t    = (a > M - 1) ? M - 1 : a;
      diff = t - pos_model;
      up   = (diff > 0);
      d    = (diff < 0) ? -diff : diff;
      fimc = d * (PASSO + 1) + 1;
      @(negedge clock);
      iniciar = 1'b1;
      alvo    = a[N-1:0];
      @(posedge clock);
      for (int c = 0; c <= fimc + 2; c++) begin
         @(negedge clock);
         k = (c - PASSO) / (PASSO + 1);
         e_pronto = (c == fimc);
         e_ocup   = (c <= fimc);
         e_vai    = (c >= PASSO) && ((c - PASSO) % (PASSO + 1) == 0) && (k < d) && up;
         e_vem    = (c >= PASSO) && ((c - PASSO) % (PASSO + 1) == 0) && (k < d) && !up;
         tests += 4;
         if (vai !== e_vai) begin
            fails++;
            $display("FAIL %s vai c=%0d got %b want %b", nome, c, vai, e_vai);
         end
         if (vem !== e_vem) begin
            fails++;
            $display("FAIL %s vem c=%0d got %b want %b", nome, c, vem, e_vem);
         end
         if (pronto !== e_pronto) begin
            fails++;
            $display("FAIL %s pronto c=%0d got %b want %b", nome, c, pronto, e_pronto);
         end
         if (ocupado !== e_ocup) begin
            fails++;
            $display("FAIL %s ocupado c=%0d got %b want %b", nome, c, ocupado, e_ocup);
         end
         iniciar = 1'b0;
         if (c == mid_c) begin
            iniciar = 1'b1;
            alvo    = '0;
         end
      end
      iniciar = 1'b0;
      tests += 2;
      if (posicao !== N'(t)) begin
         fails++;
         $display("FAIL %s posicao got %0d want %0d", nome, posicao, t);
      end
      if (cnt_q !== N'(t)) begin
         fails++;
         $display("FAIL %s contador got %0d want %0d", nome, cnt_q, t);
      end
      pos_model = t;
   endtask

   task automatic test_reset();
      do_reset();
      tests += 5;
      if ({vai, vem, pronto, ocupado} !== 4'b0000) begin
         fails++;
         $display("FAIL reset saidas got %b want 0000", {vai, vem, pronto, ocupado});
      end
      if (posicao !== '0) begin
         fails++;
         $display("FAIL reset posicao got %0d want 0", posicao);
      end
      if (cnt_q !== '0) begin
         fails++;
         $display("FAIL reset contador got %0d want 0", cnt_q);
      end
      if (dut.estado_q !== ST_OCIOSO) begin
         fails++;
         $display("FAIL reset estado got %0d want %0d", dut.estado_q, EST_OCIOSO);
      end
      if (cnt_fim !== 1'b0) begin
         fails++;
         $display("FAIL reset cnt_fim got %b want 0", cnt_fim);
      end
   endtask

   task automatic test_sobe();
      run_move(3, -1, "sobe");
   endtask

   task automatic test_desce();
      run_move(1, -1, "desce");
   endtask

   task automatic test_igual();
      run_move(1, -1, "igual");
   endtask

   task automatic test_ignora();
      run_move(10, 2 * PASSO + 1, "ignora");
   endtask

   task automatic test_satura();
      do_reset();
      run_move(120, -1, "satura");
      tests++;
      if (cnt_fim !== 1'b1) begin
         fails++;
         $display("FAIL satura cnt_fim got %b want 1", cnt_fim);
      end
      run_move(127, -1, "satura_topo");
   endtask

   task automatic test_aleatorio();
      int a, mid;
      for (int i = 0; i < 8; i++) begin
         a   = $urandom_range(0, 127);
         mid = ($urandom_range(0, 3) == 0) ? $urandom_range(0, PASSO) : -1;
         repeat ($urandom_range(0, 3)) @(negedge clock);
         run_move(a, mid, "aleatorio");
      end
   endtask

   task automatic test_zera_passo();
      do_reset();
      @(negedge clock);
      iniciar = 1'b1;
      alvo    = 7'd5;
      @(posedge clock);
      @(negedge clock);
      iniciar = 1'b0;
      repeat (PASSO) @(negedge clock);
      tests++;
      if (vai !== 1'b1) begin
         fails++;
         $display("FAIL zera_passo vai_antes got %b want 1", vai);
      end
      zera_s = 1'b1;
      @(negedge clock);
      tests += 4;
      if ({vai, vem, pronto, ocupado} !== 4'b0000) begin
         fails++;
         $display("FAIL zera_passo saidas got %b want 0000", {vai, vem, pronto, ocupado});
      end
      if (posicao !== '0) begin
         fails++;
         $display("FAIL zera_passo posicao got %0d want 0", posicao);
      end
      if (cnt_q !== '0) begin
         fails++;
         $display("FAIL zera_passo contador got %0d want 0", cnt_q);
      end
      if (dut.estado_q !== ST_OCIOSO) begin
         fails++;
         $display("FAIL zera_passo estado got %0d want %0d", dut.estado_q, EST_OCIOSO);
      end
      zera_s    = 1'b0;
      pos_model = 0;
      run_move(2, -1, "apos_zera");
   endtask

   initial begin
      test_reset();
      test_sobe();
      test_desce();
      test_igual();
      test_ignora();
      test_satura();
      test_aleatorio();
      test_zera_passo();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
